ram_arbiter: RTL and testbench



---
 rtl/ts_pkg.sv | 26 ++
 rtl/arb_slot.sv | 63 ++++++
 rtl/ram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ts_pkg
// Purpose  : Shared types for the TS2068 RAM arbiter: FSM state encoding and
//            requester identifiers used to index the per-requester slots.
// Revision : 1.0 - initial release
// ============================================================================
package ts_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_REQ = 3;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_VID = 2'd0;
    localparam req_id_t REQ_CPU = 2'd1;
    localparam req_id_t REQ_DMA = 2'd2;

endpackage
`default_nettype wire

// File: rtl/arb_slot.sv
`default_nettype none
// ============================================================================
// Module   : arb_slot
// Purpose  : One requester slot of the RAM arbiter. Latches a strobed request
//            (address, write flag, write data), holds it pending until the
//            arbiter completes it, and holds the returned read data.
// Ports    : clock, reset (sync, active-low)
//            req/wr_in/a_in/d_in  strobe and request fields
//            clear                completion of this slot's access
//            cap/cap_data         load read data into q
//            pend/wr/addr/data    latched request
//            q                    held read data
//            overrun_hit          strobe seen while still pending
// Revision : 1.0 - initial release
// ============================================================================
module arb_slot #(
    parameter int AW = 18
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req,
    input  logic          wr_in,
    input  logic [AW-1:0] a_in,
    input  logic [7:0]    d_in,
    input  logic          clear,
    input  logic          cap,
    input  logic [7:0]    cap_data,
    output logic          pend,
    output logic          wr,
    output logic [AW-1:0] addr,
    output logic [7:0]    data,
    output logic [7:0]    q,
    output logic          overrun_hit
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pend <= 1'b0;
            wr   <= 1'b0;
            addr <= '0;
            data <= 8'h00;
            q    <= 8'h00;
        end else begin
            // A strobe in the completion cycle replaces the finishing request.
            if (req && (!pend || clear)) begin
                pend <= 1'b1;
                wr   <= wr_in;
                addr <= a_in;
                data <= d_in;
            end else if (clear) begin
                pend <= 1'b0;
            end
            if (cap) begin
                q <= cap_data;
            end
        end
    end

    // The original request stands; the extra strobe is only reported.
    assign overrun_hit = req && pend && !clear;

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Shares one synchronous single-port RAM between video fetch, the
//            Z80 bus and a DMA port. One access in flight at a time; priority
//            video > CPU > DMA, with DMA promoted above CPU after FAIR
//            consecutive non-DMA grants while it waits.
// Ports    : clock, reset (sync, active-low)
//            vid*/cpu*/dma*  requester strobes, fields, read data and acks
//            ram*            RAM controller port
//            overrun         sticky: strobe while same requester pending
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ts_pkg::*;
#(
    parameter int AW   = 18,
    parameter int LAT  = 2,
    parameter int FAIR = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vidReq,
    input  logic [AW-1:0] vidA,
    output logic [7:0]    vidQ,
    output logic          vidAck,
    input  logic          cpuReq,
    input  logic          cpuW,
    input  logic [AW-1:0] cpuA,
    input  logic [7:0]    cpuD,
    output logic [7:0]    cpuQ,
    output logic          cpuAck,
    input  logic          dmaReq,
    input  logic          dmaW,
    input  logic [AW-1:0] dmaA,
    input  logic [7:0]    dmaD,
    output logic [7:0]    dmaQ,
    output logic          dmaAck,
    output logic [AW-1:0] ramA,
    output logic [7:0]    ramD,
    output logic          ramWe,
    input  logic [7:0]    ramQ,
    output logic          overrun
);

    localparam int            FW       = $clog2(FAIR + 1);
    localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR);
    localparam logic [2:0]    LAT_LOAD = 3'(LAT - 1);

    state_t        state;
    state_t        state_nx;
    req_id_t       grant;
    req_id_t       win;
    logic [2:0]    lat_cnt;
    logic [FW-1:0] fair_cnt;

    logic [NUM_REQ-1:0] req_v;
    logic [NUM_REQ-1:0] we_v;
    logic [NUM_REQ-1:0] pend_v;
    logic [NUM_REQ-1:0] wr_v;
    logic [NUM_REQ-1:0] clr_v;
    logic [NUM_REQ-1:0] cap_v;
    logic [NUM_REQ-1:0] ovr_v;
    logic [AW-1:0]      a_in  [NUM_REQ];
    logic [AW-1:0]      a_q   [NUM_REQ];
    logic [7:0]         d_in  [NUM_REQ];
    logic [7:0]         d_q   [NUM_REQ];
    logic [7:0]         q_q   [NUM_REQ];
    logic               cur_wr;

    assign req_v = {dmaReq, cpuReq, vidReq};
    assign we_v  = {dmaW, cpuW, 1'b0};          // video only ever reads
    assign a_in[REQ_VID] = vidA;
    assign a_in[REQ_CPU] = cpuA;
    assign a_in[REQ_DMA] = dmaA;
    assign d_in[REQ_VID] = 8'h00;
    assign d_in[REQ_CPU] = cpuD;
    assign d_in[REQ_DMA] = dmaD;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
            arb_slot #(.AW(AW)) u_slot (
                .clock       (clock),
                .reset       (reset),
                .req         (req_v[i]),
                .wr_in       (we_v[i]),
                .a_in        (a_in[i]),
                .d_in        (d_in[i]),
                .clear       (clr_v[i]),
                .cap         (cap_v[i]),
                .cap_data    (ramQ),
                .pend        (pend_v[i]),
                .wr          (wr_v[i]),
                .addr        (a_q[i]),
                .data        (d_q[i]),
                .q           (q_q[i]),
                .overrun_hit (ovr_v[i])
            );
        end
    endgenerate

    assign cur_wr = wr_v[grant];

    // Priority from pending latches only; DMA jumps CPU once starved.
    always_comb begin
        win = REQ_DMA;
        if (pend_v[REQ_VID]) begin
            win = REQ_VID;
        end else if (pend_v[REQ_DMA] && (fair_cnt == FAIR_MAX)) begin
            win = REQ_DMA;
        end else if (pend_v[REQ_CPU]) begin
            win = REQ_CPU;
        end
    end

    // State register with grant, latency and fairness bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= REQ_VID;
            lat_cnt  <= 3'd0;
            fair_cnt <= '0;
            overrun  <= 1'b0;
        end else begin
            state <= state_nx;
            if ((state == IDLE) && (|pend_v)) begin
                grant <= win;
                if (win == REQ_DMA) begin
                    fair_cnt <= '0;
                end else if (pend_v[REQ_DMA] && (fair_cnt != FAIR_MAX)) begin
                    fair_cnt <= fair_cnt + 1'b1;
                end
            end
            if (state == ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state == WAIT) && (lat_cnt != 3'd0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (|ovr_v) begin
                overrun <= 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|pend_v) state_nx = ISSUE;
            ISSUE:   state_nx = (cur_wr || (LAT == 1)) ? DONE : WAIT;
            WAIT:    if (lat_cnt == 3'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs. RAM address/data stay on the granted slot's latched fields
    // for the whole access; ramQ is sampled on the edge that enters DONE so
    // the new Q appears together with the ack.
    always_comb begin
        ramA   = '0;
        ramD   = 8'h00;
        ramWe  = 1'b0;
        clr_v  = '0;
        cap_v  = '0;
        if (state != IDLE) begin
            ramA = a_q[grant];
            ramD = d_q[grant];
        end
        if (state == ISSUE) begin
            ramWe = cur_wr;
        end
        if (state == DONE) begin
            clr_v[grant] = 1'b1;
        end
        if ((state != DONE) && (state_nx == DONE) && !cur_wr) begin
            cap_v[grant] = 1'b1;
        end
    end

    assign vidAck = clr_v[REQ_VID];
    assign cpuAck = clr_v[REQ_CPU];
    assign dmaAck = clr_v[REQ_DMA];
    assign vidQ   = q_q[REQ_VID];
    assign cpuQ   = q_q[REQ_CPU];
    assign dmaQ   = q_q[REQ_DMA];

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter. A transaction-level model
//            tracks pending requests and the phase of the access in flight;
//            every cycle the DUT outputs are compared against it. Directed
//            scenarios add literal timing/data expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int AW   = 18;
    localparam int LAT  = 2;
    localparam int FAIR = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          vidReq = 1'b0;
    logic [AW-1:0] vidA = '0;
    logic [7:0]    vidQ;
    logic          vidAck;
    logic          cpuReq = 1'b0;
    logic          cpuW = 1'b0;
    logic [AW-1:0] cpuA = '0;
    logic [7:0]    cpuD = 8'h00;
    logic [7:0]    cpuQ;
    logic          cpuAck;
    logic          dmaReq = 1'b0;
    logic          dmaW = 1'b0;
    logic [AW-1:0] dmaA = '0;
    logic [7:0]    dmaD = 8'h00;
    logic [7:0]    dmaQ;
    logic          dmaAck;
    logic [AW-1:0] ramA;
    logic [7:0]    ramD;
    logic          ramWe;
    logic [7:0]    ramQ;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ram_arbiter #(.AW(AW), .LAT(LAT), .FAIR(FAIR)) dut (
        .clock(clock), .reset(reset),
        .vidReq(vidReq), .vidA(vidA), .vidQ(vidQ), .vidAck(vidAck),
        .cpuReq(cpuReq), .cpuW(cpuW), .cpuA(cpuA), .cpuD(cpuD),
        .cpuQ(cpuQ), .cpuAck(cpuAck),
        .dmaReq(dmaReq), .dmaW(dmaW), .dmaA(dmaA), .dmaD(dmaD),
        .dmaQ(dmaQ), .dmaAck(dmaAck),
        .ramA(ramA), .ramD(ramD), .ramWe(ramWe), .ramQ(ramQ),
        .overrun(overrun)
    );

    wire [2:0] acks = {dmaAck, cpuAck, vidAck};

    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // ---------------- RAM model: LAT-stage read pipeline ----------------
    logic [AW-1:0] s_a  = '0;
    logic [7:0]    s_d  = 8'h00;
    logic          s_we = 1'b0;
    logic [7:0]    ram_w [int];
    logic [7:0]    pipe  [LAT];

    initial for (int k = 0; k < LAT; k++) pipe[k] = 8'h00;

    always @(negedge clock) begin
        s_a  = ramA;
        s_d  = ramD;
        s_we = ramWe;
    end

    always @(posedge clock) begin
        pipe[0] <= ram_w.exists(int'(s_a)) ? ram_w[int'(s_a)] : init_byte(s_a);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        if (s_we) ram_w[int'(s_a)] = s_d;
    end

    assign ramQ = pipe[LAT-1];

    // ---------------- Behavioural model ----------------
    // phase: -1 = port idle, 0 = first cycle of the granted access, and the
    // access completes (ack cycle) at phase dlen(cur).
    int            phase = -1;
    int            cur   = 0;
    int            mfair = 0;
    bit            movr  = 1'b0;
    bit            mp [3];
    logic          mw [3];
    logic [AW-1:0] ma [3];
    logic [7:0]    md [3];
    logic [7:0]    mq [3];
    logic [7:0]    mmem [int];

    function automatic int dlen(input int id);
        return mw[id] ? 1 : LAT + 1;
    endfunction

    function automatic logic [7:0] mrd(input logic [AW-1:0] a);
        return mmem.exists(int'(a)) ? mmem[int'(a)] : init_byte(a);
    endfunction

    always @(posedge clock) begin : model
        logic          rq [3];
        logic          iw [3];
        logic [AW-1:0] ia [3];
        logic [7:0]    id [3];
        int            w;
        rq[0] = vidReq; iw[0] = 1'b0; ia[0] = vidA; id[0] = 8'h00;
        rq[1] = cpuReq; iw[1] = cpuW; ia[1] = cpuA; id[1] = cpuD;
        rq[2] = dmaReq; iw[2] = dmaW; ia[2] = dmaA; id[2] = dmaD;
        if (!reset) begin
            phase = -1; cur = 0; mfair = 0; movr = 1'b0;
            for (int i = 0; i < 3; i++) begin
                mp[i] = 1'b0; mw[i] = 1'b0; ma[i] = '0; md[i] = 8'h00; mq[i] = 8'h00;
            end
        end else begin
            if (phase == -1) begin
                if (mp[0] || mp[1] || mp[2]) begin
                    if (mp[0])                    w = 0;
                    else if (mp[2] && mfair == FAIR) w = 2;
                    else if (mp[1])               w = 1;
                    else                          w = 2;
                    if (w == 2)                   mfair = 0;
                    else if (mp[2] && mfair < FAIR) mfair++;
                    cur   = w;
                    phase = 0;
                end
            end else if (phase == dlen(cur)) begin
                mp[cur] = 1'b0;
                phase   = -1;
            end else begin
                if (phase == 0 && mw[cur]) mmem[int'(ma[cur])] = md[cur];
                phase++;
                if (phase == dlen(cur) && !mw[cur]) mq[cur] = mrd(ma[cur]);
            end
            for (int i = 0; i < 3; i++) begin
                if (rq[i]) begin
                    if (mp[i]) movr = 1'b1;
                    else begin
                        mp[i] = 1'b1; mw[i] = iw[i]; ma[i] = ia[i]; md[i] = id[i];
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- Per-cycle compare against the model ----------------
    always @(negedge clock) begin : compare
        logic [AW-1:0] ea;
        logic [7:0]    ed;
        logic          ewe;
        logic [2:0]    eack;
        if (cyc > 0) begin
            ea = '0; ed = 8'h00; ewe = 1'b0; eack = 3'b000;
            if (phase >= 0) begin
                ea  = ma[cur];
                ed  = md[cur];
                ewe = (phase == 0) && mw[cur];
                if (phase == dlen(cur)) eack[cur] = 1'b1;
            end
            chk("ramA", 32'(ramA), 32'(ea));
            chk("ramD", 32'(ramD), 32'(ed));
            chk("ramWe", 32'(ramWe), 32'(ewe));
            chk("acks", 32'(acks), 32'(eack));
            chk("vidQ", 32'(vidQ), 32'(mq[0]));
            chk("cpuQ", 32'(cpuQ), 32'(mq[1]));
            chk("dmaQ", 32'(dmaQ), 32'(mq[2]));
            chk("overrun", 32'(overrun), 32'(movr));
        end
    end

    // Record what the RAM port showed on each write cycle.
    int            we_cnt = 0;
    logic [AW-1:0] we_a   = '0;
    logic [7:0]    we_d   = 8'h00;
    always @(negedge clock) if (ramWe) begin
        we_cnt++;
        we_a = ramA;
        we_d = ramD;
    end

    // ---------------- Stimulus helpers ----------------
    task automatic pulse(input logic [2:0] rq, input logic cw, input logic dw,
                         input logic [AW-1:0] va, input logic [AW-1:0] ca,
                         input logic [AW-1:0] da, input logic [7:0] cd,
                         input logic [7:0] dd, output int e0);
        @(posedge clock); #1;
        vidReq = rq[0]; vidA = va;
        cpuReq = rq[1]; cpuW = cw; cpuA = ca; cpuD = cd;
        dmaReq = rq[2]; dmaW = dw; dmaA = da; dmaD = dd;
        e0 = cyc + 1;
        @(posedge clock); #1;
        vidReq = 1'b0; cpuReq = 1'b0; dmaReq = 1'b0;
    endtask

    task automatic wait_ack(input int idx, input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            if (acks[idx]) begin
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout requester %0d: got no ack expected ack within %0d cycles", idx, budget);
    endtask

    // ---------------- Directed scenarios ----------------
    initial begin : main
        int e0, at, at2, nd, wc0, cnt;
        bit dma_seen, post;

        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("rst_ramA", 32'(ramA), 32'h0);
        chk("rst_acks", 32'(acks), 32'h0);
        chk("rst_cpuQ", 32'(cpuQ), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);

        // CPU write
        wc0 = we_cnt;
        pulse(3'b010, 1'b1, 1'b0, '0, 18'h04000, '0, 8'h5A, 8'h00, e0);
        wait_ack(1, 20, at);
        chk("wr_latency", 32'(at - e0), 32'd2);
        chk("wr_we_cycles", 32'(we_cnt - wc0), 32'd1);
        chk("wr_ramA", 32'(we_a), 32'h04000);
        chk("wr_ramD", 32'(we_d), 32'h5A);
        repeat (3) @(posedge clock);

        // CPU read back
        pulse(3'b010, 1'b0, 1'b0, '0, 18'h04000, '0, 8'h00, 8'h00, e0);
        wait_ack(1, 20, at);
        chk("rd_latency", 32'(at - e0), 32'd4);
        chk("rd_cpuQ", 32'(cpuQ), 32'h5A);
        repeat (4) @(negedge clock);
        chk("rd_cpuQ_hold", 32'(cpuQ), 32'h5A);

        // Video and CPU reads in the same cycle
        pulse(3'b011, 1'b0, 1'b0, 18'h00010, 18'h04000, '0, 8'h00, 8'h00, e0);
        wait_ack(0, 20, at);
        chk("vid_latency", 32'(at - e0), 32'd4);
        chk("vid_vidQ", 32'(vidQ), 32'hB5);
        wait_ack(1, 20, at2);
        chk("cpu_after_vid", 32'(at2 - at), 32'd5);
        chk("cpu_cpuQ", 32'(cpuQ), 32'h5A);
        repeat (3) @(posedge clock);

        // Fairness: DMA write waits behind video then a CPU that re-strobes
        // on every ack.
        @(posedge clock); #1;
        vidReq = 1'b1; vidA = 18'h00100;
        cpuReq = 1'b1; cpuW = 1'b1; cpuA = 18'h02000; cpuD = 8'h00;
        dmaReq = 1'b1; dmaW = 1'b1; dmaA = 18'h01000; dmaD = 8'h77;
        nd = 0; dma_seen = 1'b0; post = 1'b0;
        for (int n = 0; n < 300 && !post; n++) begin
            @(posedge clock); #1;
            vidReq = 1'b0; cpuReq = 1'b0; dmaReq = 1'b0;
            if (dmaAck) dma_seen = 1'b1;
            if (vidAck || cpuAck) begin
                if (!dma_seen) nd++;
                else if (cpuAck) post = 1'b1;
            end
            if (cpuAck && !dma_seen) begin
                cpuReq = 1'b1;
                cpuA   = 18'h02000 + 18'(n);
                cpuD   = 8'(n);
            end
        end
        chk("fair_grants", 32'(nd), 32'd8);
        chk("fair_dma_seen", 32'(dma_seen), 32'd1);
        chk("fair_cpu_after", 32'(post), 32'd1);
        repeat (3) @(posedge clock);

        // Overrun: second CPU strobe while the first is pending
        chk("ovr_before", 32'(overrun), 32'd0);
        pulse(3'b010, 1'b0, 1'b0, '0, 18'h00123, '0, 8'h00, 8'h00, e0);
        pulse(3'b010, 1'b0, 1'b0, '0, 18'h00200, '0, 8'h00, 8'h00, at2);
        wait_ack(1, 20, at);
        chk("ovr_latency", 32'(at - e0), 32'd4);
        chk("ovr_cpuQ", 32'(cpuQ), 32'h86);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        repeat (4) @(posedge clock);

        // Reset during WAIT of a video read
        pulse(3'b001, 1'b0, 1'b0, 18'h00010, '0, '0, 8'h00, 8'h00, e0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("rstw_ramA", 32'(ramA), 32'h0);
        chk("rstw_vidQ", 32'(vidQ), 32'h0);
        chk("rstw_overrun", 32'(overrun), 32'h0);
        cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (vidAck) cnt++;
        end
        chk("rstw_no_ack", 32'(cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
